// File: rtl/sand_drop_ctrl_if.sv
// rtl/sand_drop_ctrl_if.sv - drop request handshake bundle for sand_drop_ctrl
// Purpose: groups the request valid/ready handshake and the requested drop
//          coordinates into one interface.
// Signals: req_valid_i  requester -> controller  drop request
//          req_ready_o  controller -> requester  accept (handshake when both high)
//          req_x_i      requester -> controller  requested column (9 bits)
//          req_y_i      requester -> controller  requested row (9 bits)
// Modports: master = requester side, slave = controller side.
`timescale 1ns/1ps
interface sand_drop_ctrl_if;
   logic       req_valid_i;
   logic       req_ready_o;
   logic [8:0] req_x_i;
   logic [8:0] req_y_i;

   modport master (output req_valid_i, output req_x_i, output req_y_i, input req_ready_o);
   modport slave  (input req_valid_i, input req_x_i, input req_y_i, output req_ready_o);
endinterface

// File: rtl/sand_drop_ctrl.sv
// rtl/sand_drop_ctrl.sv - sandpile drop sequencer: accept a drop, pulse it, wait for settle
// Purpose: accepts a drop request inside the active window, pulses drop_o for
//          one cycle, then watches the array's collapse flags until two quiet
//          cycles in a row (or the settle timeout) and pulses done_o.
// Ports:   clk, rst (sync, active-high)
//          req           sand_drop_ctrl_if.slave request handshake + coordinates
//          activeRows_i / activeCols_i  active window size
//          collapse_i    per-cell collapse flags, index r*COLS+c
//          activated_o, drop_o, drop_x_o, drop_y_o   array control
//          done_o, timeout_o, reject_o               status
//          aval_cnt_o, drop_cnt_o                    statistics
// Config:  define SAND_DROP_CTRL_STATS_EN to build the avalanche / drop
//          counters; otherwise aval_cnt_o and drop_cnt_o are tied to 0.
`timescale 1ns/1ps
module sand_drop_ctrl #(
   parameter int ROWS       = 5,
   parameter int COLS       = 5,
   parameter int SETTLE_MAX = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   sand_drop_ctrl_if.slave            req,
   input  logic [$clog2(ROWS+1)-1:0]  activeRows_i,
   input  logic [$clog2(COLS+1)-1:0]  activeCols_i,
   input  logic [ROWS*COLS-1:0]       collapse_i,
   output logic                       activated_o,
   output logic                       drop_o,
   output logic [8:0]                 drop_x_o,
   output logic [8:0]                 drop_y_o,
   output logic                       done_o,
   output logic                       timeout_o,
   output logic                       reject_o,
   output logic [15:0]                aval_cnt_o,
   output logic [15:0]                drop_cnt_o
);

   typedef enum logic [1:0] {IDLE, DROP, SETTLE, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] settle_cnt_q;
   logic        prev_zero_q;
   logic        reject_q;
   logic        timeout_q;
   logic        handshake, in_window, accept, reject;
   logic        any_collapse, stable, settle_last, settle_exit;

   assign handshake    = req.req_valid_i && (state_q == IDLE);
   assign in_window    = (req.req_x_i < 9'(activeCols_i)) && (req.req_y_i < 9'(activeRows_i));
   assign accept       = handshake && in_window;
   assign reject       = handshake && !in_window;
   assign any_collapse = |collapse_i;
   // collapse_i is registered in the array, so one quiet cycle can still be
   // followed by a late collapse; require two quiet cycles in a row.
   assign stable       = !any_collapse && prev_zero_q;
   // Last settle cycle once the counter would reach SETTLE_MAX.
   assign settle_last  = ({1'b0, settle_cnt_q} + 17'd1) >= 17'(SETTLE_MAX);
   assign settle_exit  = (state_q == SETTLE) && (stable || settle_last);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = DROP;
         DROP:    state_d = SETTLE;
         SETTLE:  if (settle_exit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         settle_cnt_q <= 16'd0;
         prev_zero_q  <= 1'b0;
         reject_q     <= 1'b0;
         timeout_q    <= 1'b0;
         drop_x_o     <= 9'd0;
         drop_y_o     <= 9'd0;
      end else begin
         state_q      <= state_d;
         reject_q     <= reject;
         settle_cnt_q <= (state_q == SETTLE) ? settle_cnt_q + 16'd1 : 16'd0;
         prev_zero_q  <= (state_q == SETTLE) && !any_collapse;
         if (accept) begin
            drop_x_o  <= req.req_x_i;
            drop_y_o  <= req.req_y_i;
            timeout_q <= 1'b0;
         end else if (settle_exit && !stable) begin
            // stability takes precedence over timeout in the same cycle
            timeout_q <= 1'b1;
         end
      end
   end

   assign req.req_ready_o = (state_q == IDLE);
   assign drop_o          = (state_q == DROP);
   assign activated_o     = (state_q == DROP) || (state_q == SETTLE);
   assign done_o          = (state_q == DONE);
   assign reject_o        = reject_q;
   assign timeout_o       = timeout_q;

`ifdef SAND_DROP_CTRL_STATS_EN
   logic [15:0] aval_q, aval_nxt, aval_out_q, drop_cnt_q;

   assign aval_nxt = (any_collapse && (aval_q != 16'hFFFF)) ? aval_q + 16'd1 : aval_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         aval_q     <= 16'd0;
         aval_out_q <= 16'd0;
         drop_cnt_q <= 16'd0;
      end else begin
         if (accept) begin
            aval_q     <= 16'd0;
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end else if (state_q == SETTLE) begin
            aval_q <= aval_nxt;
         end
         // load on the SETTLE->DONE edge so the value is visible during DONE,
         // including a collapse seen in the final settle cycle
         if (settle_exit) aval_out_q <= aval_nxt;
      end
   end

   assign aval_cnt_o = aval_out_q;
   assign drop_cnt_o = drop_cnt_q;
`else
   assign aval_cnt_o = 16'd0;
   assign drop_cnt_o = 16'd0;
`endif

endmodule
